// File: rtl/uc_engine_pq.sv
// Per-engine implied-unit-clause queue: unsorted literal slots with a combinational
// min-|lit| selector, push deduplication, complement (conflict) and overflow detection.
module uc_engine_pq #(
  parameter int DEPTH       = 8,
  parameter int LIT_IDX_MAX = 255,
  parameter int LIT_W       = $clog2(LIT_IDX_MAX) + 1,
  localparam int CNT_W      = $clog2(DEPTH) + 1,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_valid,
  input  logic signed [LIT_W-1:0] push_lit,
  input  logic                    pop,
  input  logic                    flush,
  output logic signed [LIT_W-1:0] min_lit,
  output logic                    valid,
  output logic                    empty,
  output logic                    full,
  output logic [CNT_W-1:0]        count,
  output logic                    conflict,
  output logic                    overflow
);

  logic signed [LIT_W-1:0] lit_q [DEPTH];
  logic signed [LIT_W-1:0] lit_d [DEPTH];
  logic [DEPTH-1:0]        vld_q, vld_d, vld_pp;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    conflict_q, conflict_d;
  logic                    overflow_q, overflow_d;

  logic                    min_found;
  logic [IDX_W-1:0]        min_idx;
  logic [LIT_W-1:0]        min_mag;
  logic                    pop_eff, push_act, dup, comp, free_found, do_write;
  logic [IDX_W-1:0]        free_idx;
  logic signed [LIT_W-1:0] push_neg;

  function automatic logic [LIT_W-1:0] mag(input logic signed [LIT_W-1:0] l);
    return l[LIT_W-1] ? $unsigned(-l) : $unsigned(l);
  endfunction

  // NOTE: every variable written here gets a default before the loop, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    min_found = 1'b0;
    min_idx   = '0;
    min_mag   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (!min_found || mag(lit_q[i]) < min_mag)) begin
        min_found = 1'b1;
        min_idx   = IDX_W'(i);
        min_mag   = mag(lit_q[i]);
      end
    end
  end

  assign pop_eff  = pop && min_found;
  assign push_act = push_valid && (push_lit != '0);
  assign push_neg = -push_lit;

  // Push is classified against the contents left after this cycle's pop.
  always_comb begin
    vld_pp = vld_q;
    if (pop_eff) vld_pp[min_idx] = 1'b0;
    dup        = 1'b0;
    comp       = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_pp[i] && lit_q[i] == push_lit) dup  = 1'b1;
      if (vld_pp[i] && lit_q[i] == push_neg) comp = 1'b1;
      if (!vld_pp[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign do_write = push_act && !dup && !comp && free_found;

  always_comb begin
    vld_d      = vld_pp;
    lit_d      = lit_q;
    count_d    = count_q - CNT_W'(pop_eff) + CNT_W'(do_write);
    conflict_d = conflict_q | (push_act && !dup && comp);
    overflow_d = overflow_q | (push_act && !dup && !comp && !free_found);
    if (do_write) begin
      vld_d[free_idx] = 1'b1;
      lit_d[free_idx] = push_lit;
    end
    if (flush) begin
      vld_d      = '0;
      count_d    = '0;
      conflict_d = 1'b0;
      overflow_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      count_q    <= '0;
      conflict_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      count_q    <= count_d;
      conflict_q <= conflict_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: literal slots are left unreset on purpose; a slot's contents are only
  // ever read through its valid bit, which is reset.
  always_ff @(posedge clk) begin
    lit_q <= lit_d;
  end

  assign min_lit  = min_found ? lit_q[min_idx] : '0;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign valid    = !empty;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign conflict = conflict_q;
  assign overflow = overflow_q;

endmodule

// File: doc/uc_engine_pq.md
# uc_engine_pq

Per-engine implied-unit-clause priority queue that sits directly upstream of the unit-clause arbiter. Each solver engine pushes newly implied literals into its own instance. The instance continuously presents its smallest-variable pending literal (`min_lit`) with `valid`/`empty`/`full` status, and the arbiter pops entries either round-robin or in mask order. The block also deduplicates pushes and detects an engine-local conflict: an `x` / `-x` pair within the same queue.

## Interface
- `DEPTH`, 8: number of literal slots; power of two, minimum 2.
- `LIT_W`, `$clog2(LIT_IDX_MAX)+1`: signed literal width. Positive means the variable is true, negative means false, and 0 is never a legal literal.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `push_valid`  in  1  engine presents a literal this cycle.
- `push_lit`  in  signed `LIT_W`  literal to insert; ignored when `push_valid`=0.
- `pop`  in  1  arbiter consumes the current `min_lit`.
- `flush`  in  1  discard all entries and clear the sticky flags (engine backtrack).
- `min_lit`  out  signed `LIT_W`  stored literal with smallest |value|; 0 when empty.
- `valid`  out  1  equals !`empty`.
- `empty`  out  1  no stored entries.
- `full`  out  1  `count` == `DEPTH`.
- `count`  out  `$clog2(DEPTH)+1`  number of stored entries.
- `conflict`  out  1  sticky: a literal's complement was pushed while the literal was stored.
- `overflow`  out  1  sticky: a non-duplicate push was dropped because the queue was full.

## Operation
- Storage is `DEPTH` slots, each holding a literal and a valid bit. Storage is unsorted.
- `min_lit` is combinational over the registered slots: the valid slot with minimum |lit|.
  - Two valid slots never share |lit|: duplicates are dropped and complements are rejected.
- Reset and flush each clear all valid bits, `count`, `conflict` and `overflow`.
  - `rst` takes priority over everything.
  - `flush` takes priority over push and pop in the same cycle.
- Per-cycle order (no reset, no flush):
  1. If `pop` and !`empty`, the slot holding the current `min_lit` is invalidated.
  2. The push is evaluated against the post-pop contents.
- Push classification, against post-pop contents:
  - Equal literal present: dropped silently. Counts as accepted; no flag.
  - Complement (`-push_lit`) present: dropped; `conflict` is set.
  - Neither present, and a free slot exists post-pop: written into the lowest-index free slot.
  - Neither present, and no free slot: dropped; `overflow` is set.
- `push_lit` == 0 with `push_valid`: ignored entirely, with no flag set.
- Pop while empty: ignored, no state change.
- Push and pop together while full: the pop frees a slot, so the push is accepted, `count` is unchanged and `overflow` is not set.
- Push equal to the literal being popped in the same cycle: treated as a new entry (pop-first) and re-inserted.
- `count` arithmetic:
  - next = count − pop_eff + push_eff.
  - It never exceeds `DEPTH` and never goes below 0.
- Width: |lit| is computed as the `LIT_W`-bit unsigned magnitude; comparisons are unsigned on the magnitude.

## Timing
- Reset values: `min_lit`=0, `valid`=0, `empty`=1, `full`=0, `count`=0, `conflict`=0, `overflow`=0.
- Push at edge N: the literal is visible on `min_lit`/`count` after edge N, i.e. during cycle N+1. Zero combinational path from `push_*` to any output.
- Pop sampled at edge N: the next minimum is presented during cycle N+1. The arbiter may pop on back-to-back cycles.
- `pop` does not combinationally affect outputs within the same cycle.
- Sticky flags assert the cycle after the offending push and hold until `rst` or `flush`.
- `flush` asserted with `push_valid`: the push is discarded, and the queue is empty after the edge.

## Test plan
- Reset, then push +7, −3, +12 on consecutive cycles, no pops.
  - Required: `min_lit`=+7 then −3 then −3; `count`=3; `empty`=0.
  - Then pop ×3: `min_lit` becomes +7, then +12, then 0, and `empty`=1.
- Push +5, then +5 again.
  - Required: `count`=1 and no flags.
  - Then push −5: `count` stays 1, `conflict`=1 from the next cycle, `min_lit`=+5.
- Fill `DEPTH`=8 with +1..+8, giving `full`=1.
  - Push +9 alone: dropped, `overflow`=1, `count`=8.
  - Push +9 with `pop`: +1 is removed and +9 accepted; `count`=8, `min_lit`=+2.
- Pop while empty for 3 cycles.
  - Required: `count`=0, `min_lit`=0, and no flags.
- Stored {+4, −2}, with `conflict` already set.
  - Apply `flush` together with push +1.
  - Required: the next cycle shows `count`=0, `empty`=1, `conflict`=0, `overflow`=0.
- Stored {+3}: pop and push +3 in the same cycle.
  - Required: `count`=1, `min_lit`=+3, no flags.
  - Assert `rst` mid-stream with 4 entries: the next cycle shows all outputs at their reset values.
